// File: rtl/bitop_pkg.sv
// Shared types and helpers for the bit-operation stream FIFO.
//   zop_t          : selectable z operation (AND / OR / NAND; code 3 behaves as AND)
//   bitop_apply    : single-bit evaluation of a z operation
//   bitop_count_w  : width of an occupancy counter able to hold 0..depth
package bitop_pkg;

  typedef enum logic [1:0] {
    ZOP_AND  = 2'd0,
    ZOP_OR   = 2'd1,
    ZOP_NAND = 2'd2,
    ZOP_RSVD = 2'd3
  } zop_t;

  // Per-bit so callers of any width can loop over it without width adapters.
  function automatic logic bitop_apply(zop_t op, logic y, logic x);
    case (op)
      ZOP_OR:   return y | x;
      ZOP_NAND: return ~(y & x);
      default:  return y & x;  // AND, and the reserved code
    endcase
  endfunction

  function automatic int bitop_count_w(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bitop_if.sv
// Valid/ready stream bundle shared by one producer/consumer pair.
//   valid, ready : handshake; a beat transfers on a rising edge where both are 1.
//                  The sender holds its payload and valid stable while valid & ~ready.
//   y, x         : operand payload (producer -> block)
//   z, w         : result payload (block -> consumer)
// Modports are written from the block's point of view:
//   SRC : block receives operands (valid/y/x in, ready out)
//   SNK : block sends results     (valid/z/w out, ready in)
interface bitop_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] z;
  logic [WIDTH-1:0] w;

  modport SRC (input valid, input y, input x, output ready);
  modport SNK (output valid, output z, output w, input ready);
endinterface

// File: rtl/bitop_fifo_mem.sv
// Storage array for the stream FIFO: one synchronous write port, one
// asynchronous read port, no reset (contents are only ever read from
// slots the control logic knows to be valid).
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write slot
//   i_wdata : write data
//   i_raddr : read slot
//   o_rdata : read data (combinational from i_raddr)
module bitop_fifo_mem #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/bitop_stream_fifo.sv
// Operand stream in, result stream out: each accepted (y,x) pair is turned
// into z = zop(y,x) and w = y ^ x at enqueue time and buffered in a
// DEPTH-entry FIFO (DEPTH must be a power of two, >= 2).
//   i_clk, i_arst_n : clock, asynchronous active-low reset
//   p_src           : operand stream (valid/ready, y, x)
//   p_snk           : result stream (valid/ready, z, w), show-ahead
//   i_zop_wr/i_zop  : load the z-operation register; applies to a push in the same cycle
//   i_flush         : drop all buffered entries; wins over push and pop
//   o_count         : occupancy
//   o_overflow      : sticky, producer offered data while full
module bitop_stream_fifo
  import bitop_pkg::*;
#(
  parameter int   WIDTH = 8,
  parameter int   DEPTH = 4,
  parameter zop_t ZOP   = ZOP_AND
) (
  input  logic                             i_clk,
  input  logic                             i_arst_n,
  bitop_if.SRC                             p_src,
  bitop_if.SNK                             p_snk,
  input  logic                             i_zop_wr,
  input  zop_t                             i_zop,
  input  logic                             i_flush,
  output logic [bitop_count_w(DEPTH)-1:0]  o_count,
  output logic                             o_overflow
);

  localparam int            CW       = bitop_count_w(DEPTH);
  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               ovf_q, ovf_d;
  zop_t               zop_q, zop_d;

  logic               full, not_empty, push, pop;
  zop_t               zop_eff;
  logic [WIDTH-1:0]   z_c, w_c;
  logic [2*WIDTH-1:0] rdata;

  // Handshake sides depend only on registered state (plus flush for ready),
  // so there is no combinational path from p_snk.ready to p_src.ready.
  assign full        = (count_q == FULL_CNT);
  assign not_empty   = (count_q != '0);
  assign p_src.ready = ~full & ~i_flush;
  assign p_snk.valid = not_empty;
  assign push        = p_src.valid & p_src.ready;
  assign pop         = not_empty & p_snk.ready;

  // A z-op write takes effect for a push in the same cycle.
  always_comb begin
    zop_eff = i_zop_wr ? i_zop : zop_q;
    z_c     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      z_c[i] = bitop_apply(zop_eff, p_src.y[i], p_src.x[i]);
    end
    w_c = p_src.y ^ p_src.x;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    zop_d    = i_zop_wr ? i_zop : zop_q;
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (p_src.valid && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      zop_q    <= ZOP;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      zop_q    <= zop_d;
    end
  end

  bitop_fifo_mem #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata ({z_c, w_c}),
    .i_raddr (rd_ptr_q),
    .o_rdata (rdata)
  );

  // Stale memory is never exposed: outputs are zero whenever nothing is buffered.
  assign p_snk.z    = not_empty ? rdata[2*WIDTH-1:WIDTH] : '0;
  assign p_snk.w    = not_empty ? rdata[WIDTH-1:0]       : '0;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule
